// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the radix-2 divide controller
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] rem_sh, trial;
  logic ok;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial = rem_sh - {1'b0, divisor};
  assign ok = ~trial[WIDTH];
  assign rem_next = ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ok};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU controller with pipeline stall, flush annul and HI/LO results
module div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  output logic             stall_divE,
  output logic             div_doneE,
  output logic [WIDTH-1:0] lo_divE,
  output logic [WIDTH-1:0] hi_divE
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, rem_n, quo_n;
  logic qneg, rneg, sa, sb;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .quo(quo),
    .divisor(dvs),
    .rem_next(rem_n),
    .quo_next(quo_n)
  );
  assign sa = signedE & srcaE[WIDTH-1];
  assign sb = signedE & srcbE[WIDTH-1];
  assign stall_divE = ~cancelE & ((state == IDLE & startE) | state == BUSY);
  // divide by zero parks the raw dividend in rem and all ones in quo, so DONE needs no special case
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      div_doneE <= 1'b0;
      lo_divE <= '0;
      hi_divE <= '0;
    end else begin
      div_doneE <= 1'b0;
      case (state)
        IDLE: if (startE & ~cancelE) begin
          dvs <= sb ? -srcbE : srcbE;
          cnt <= CW'(WIDTH);
          if (srcbE == '0) begin
            rem <= srcaE;
            quo <= {WIDTH{DIV_ZERO_QUO[0]}};
            qneg <= 1'b0;
            rneg <= 1'b0;
            state <= DONE;
            div_doneE <= 1'b1;
          end else begin
            rem <= '0;
            quo <= sa ? -srcaE : srcaE;
            qneg <= sa ^ sb;
            rneg <= sa;
            state <= BUSY;
          end
        end
        BUSY: if (cancelE) state <= IDLE;
        else begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            div_doneE <= 1'b1;
          end
        end
        DONE: begin
          lo_divE <= qneg ? -quo : quo;
          hi_divE <= rneg ? -rem : rem;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
